// File: rtl/snn_inference_ctrl.sv
// Inference sequencer for one integrate-and-fire network: clears the network,
// rate-codes inputs for N timesteps, drains latency, counts outputs, picks a winner.
module snn_inference_ctrl #(
    parameter int NUM_INPUTS    = 4,
    parameter int NUM_OUTPUTS   = 2,
    parameter int RATE_WIDTH    = 8,
    parameter int STEP_WIDTH    = 16,
    parameter int CNT_WIDTH     = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int DRAIN_CYCLES  = 2,
    parameter int IDX_WIDTH     = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [NUM_INPUTS*RATE_WIDTH-1:0]  rates,
    input  logic [STEP_WIDTH-1:0]             num_steps,
    output logic                              busy,
    output logic                              done,
    output logic                              net_rst,
    output logic [NUM_INPUTS-1:0]             net_spike_in,
    input  logic [NUM_OUTPUTS-1:0]            net_spike_out,
    output logic [NUM_OUTPUTS*CNT_WIDTH-1:0]  spike_count,
    output logic [IDX_WIDTH-1:0]              winner,
    output logic                              winner_valid,
    output logic [2:0]                        dbg_state_o
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_e;

    // One phase counter serves CLEAR, RUN and DRAIN; wide enough for all three.
    localparam int PW = (STEP_WIDTH > 16) ? STEP_WIDTH : 16;
    localparam state_e AFTER_RUN = (DRAIN_CYCLES > 0) ? S_DRAIN : S_DONE;

    state_e                          state_q, state_d;
    logic [PW-1:0]                   cnt_q, cnt_d;
    logic [NUM_INPUTS*RATE_WIDTH-1:0] rates_q;
    logic [STEP_WIDTH-1:0]           steps_q;
    logic [RATE_WIDTH-1:0]           acc_q [NUM_INPUTS];
    logic [RATE_WIDTH-1:0]           acc_d [NUM_INPUTS];
    logic [CNT_WIDTH-1:0]            count_q [NUM_OUTPUTS];
    logic [CNT_WIDTH-1:0]            count_d [NUM_OUTPUTS];
    logic [NUM_INPUTS-1:0]           spike_q, spike_d;
    logic [IDX_WIDTH-1:0]            winner_q, winner_d;
    logic                            valid_q, valid_d;
    logic                            busy_q, done_q, net_rst_q;
    logic                            accept;
    logic [RATE_WIDTH:0]             sum_v;
    logic [CNT_WIDTH-1:0]            best_v;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end
            end
            S_CLEAR: begin
                if (cnt_q == PW'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (steps_q != '0) ? S_RUN : AFTER_RUN;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            S_RUN: begin
                if (cnt_q == PW'(steps_q) - PW'(1)) begin
                    cnt_d   = '0;
                    state_d = AFTER_RUN;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == PW'(DRAIN_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    // Spikes are computed for the cycle about to be entered, so they appear registered in RUN.
    always_comb begin
        spike_d = '0;
        sum_v   = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            acc_d[i] = acc_q[i];
            if (accept) begin
                acc_d[i] = '0;
            end else if (state_d == S_RUN) begin
                sum_v      = {1'b0, acc_q[i]} + {1'b0, rates_q[i*RATE_WIDTH +: RATE_WIDTH]};
                spike_d[i] = sum_v[RATE_WIDTH];
                acc_d[i]   = sum_v[RATE_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
            count_d[j] = count_q[j];
            if (accept) begin
                count_d[j] = '0;
            end else if ((state_q == S_RUN || state_q == S_DRAIN) && net_spike_out[j] &&
                         count_q[j] != {CNT_WIDTH{1'b1}}) begin
                count_d[j] = count_q[j] + CNT_WIDTH'(1);
            end
        end
        winner_d = winner_q;
        valid_d  = valid_q;
        best_v   = count_d[0];
        if (accept) begin
            winner_d = '0;
            valid_d  = 1'b0;
        end else if (state_d == S_DONE) begin
            winner_d = '0;
            for (int j = 1; j < NUM_OUTPUTS; j++) begin
                if (count_d[j] > best_v) begin
                    best_v   = count_d[j];
                    winner_d = IDX_WIDTH'(j);
                end
            end
            valid_d = (best_v != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rates_q   <= '0;
            steps_q   <= '0;
            spike_q   <= '0;
            winner_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            net_rst_q <= 1'b1;
            for (int i = 0; i < NUM_INPUTS; i++) acc_q[i] <= '0;
            for (int j = 0; j < NUM_OUTPUTS; j++) count_q[j] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            if (accept) begin
                rates_q <= rates;
                steps_q <= num_steps;
            end
            spike_q   <= spike_d;
            winner_q  <= winner_d;
            valid_q   <= valid_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            net_rst_q <= (state_d == S_IDLE || state_d == S_CLEAR || state_d == S_DONE);
            for (int i = 0; i < NUM_INPUTS; i++) acc_q[i] <= acc_d[i];
            for (int j = 0; j < NUM_OUTPUTS; j++) count_q[j] <= count_d[j];
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_OUTPUTS; j++) spike_count[j*CNT_WIDTH +: CNT_WIDTH] = count_q[j];
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign net_rst      = net_rst_q;
    assign net_spike_in = spike_q;
    assign winner       = winner_q;
    assign winner_valid = valid_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Bench for snn_inference_ctrl: a one-cycle-delay network stub feeds outputs back,
// and expectations come from the closed-form spike-count rule floor(N*rate/256).
module tb_snn_inference_ctrl;

    localparam int S  = 2;
    localparam int D  = 2;
    localparam int SAT_MAX = 7;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [31:0] rates;
    logic [15:0] num_steps;

    logic        busy, done, net_rst, winner, winner_valid;
    logic [3:0]  net_spike_in;
    logic [1:0]  stub_q = '0;
    logic [31:0] spike_count;
    logic [2:0]  dbg_state;

    logic        s_busy, s_done, s_net_rst, s_winner, s_winner_valid;
    logic [3:0]  s_net_spike_in;
    logic [1:0]  s_stub_q = '0;
    logic [5:0]  s_spike_count;
    logic [2:0]  s_dbg_state;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    snn_inference_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rates(rates),
        .num_steps(num_steps), .busy(busy), .done(done), .net_rst(net_rst),
        .net_spike_in(net_spike_in), .net_spike_out(stub_q), .spike_count(spike_count),
        .winner(winner), .winner_valid(winner_valid), .dbg_state_o(dbg_state)
    );

    snn_inference_ctrl #(.CNT_WIDTH(3)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rates(rates),
        .num_steps(num_steps), .busy(s_busy), .done(s_done), .net_rst(s_net_rst),
        .net_spike_in(s_net_spike_in), .net_spike_out(s_stub_q), .spike_count(s_spike_count),
        .winner(s_winner), .winner_valid(s_winner_valid), .dbg_state_o(s_dbg_state)
    );

    // Network stub: outputs mirror inputs one cycle later, held clear while in reset.
    always @(posedge clk) begin
        stub_q   <= net_rst   ? 2'b00 : net_spike_in[1:0];
        s_stub_q <= s_net_rst ? 2'b00 : s_net_spike_in[1:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_net_rst"}, 32'(net_rst), 1);
        check({tag, "_spike_in"}, 32'(net_spike_in), 0);
        check({tag, "_count"}, spike_count, 0);
        check({tag, "_winner"}, 32'(winner), 0);
        check({tag, "_wvalid"}, 32'(winner_valid), 0);
    endtask

    // Runs one sample starting at a negedge. abort_at / rst_at / mid_start are cycle
    // indices after the accepting edge (1 = first CLEAR cycle); 0 disables each.
    task automatic run_sample(input string name, input logic [31:0] rv, input int n,
                              input int abort_at, input int mid_start, input int rst_at);
        int r[4];
        int exp_in[4];
        int exp_c[2];
        int sat_c[2];
        int pulses[4];
        int busy_cnt, done_cnt, done_cyc, low_rst, viol, cyc, k, ew, sw;
        busy_cnt = 0; done_cnt = 0; done_cyc = 0; low_rst = 0; viol = 0;
        for (int i = 0; i < 4; i++) begin
            r[i]      = int'(rv[i*8 +: 8]);
            exp_in[i] = (n * r[i]) / 256;
            pulses[i] = 0;
        end
        k = (abort_at > 0) ? abort_at - S - 1 : n;
        for (int j = 0; j < 2; j++) begin
            exp_c[j] = (k * r[j]) / 256;
            sat_c[j] = (exp_c[j] > SAT_MAX) ? SAT_MAX : exp_c[j];
        end
        ew = (exp_c[1] > exp_c[0]) ? 1 : 0;
        sw = (sat_c[1] > sat_c[0]) ? 1 : 0;

        rates = rv; num_steps = 16'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 500) begin
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (!net_rst) low_rst++;
            if (net_rst && net_spike_in != 4'b0) viol++;
            for (int i = 0; i < 4; i++) if (net_spike_in[i]) pulses[i]++;
            if (!busy) break;
            abort = (cyc == abort_at);
            rst   = (cyc == rst_at);
            start = (cyc == mid_start);
            @(negedge clk);
            cyc++;
        end
        abort = 1'b0; start = 1'b0;
        check({name, "_timeout"}, 32'(busy), 0);
        check({name, "_spike_outside_run"}, 32'(viol), 0);

        if (rst_at > 0) begin
            check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(rst_at));
            check({name, "_done_pulses"}, 32'(done_cnt), 0);
            check_reset_outputs({name, "_after_rst"});
            rst = 1'b0;
        end else if (abort_at > 0) begin
            check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(abort_at));
            check({name, "_done_pulses"}, 32'(done_cnt), 0);
            check({name, "_net_rst"}, 32'(net_rst), 1);
            check({name, "_spike_in"}, 32'(net_spike_in), 0);
            check({name, "_wvalid"}, 32'(winner_valid), 0);
            check({name, "_sat_wvalid"}, 32'(s_winner_valid), 0);
        end else begin
            check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(S + n + D + 1));
            check({name, "_done_cycle"}, 32'(done_cyc), 32'(S + n + D + 1));
            check({name, "_done_pulses"}, 32'(done_cnt), 1);
            check({name, "_net_rst_low"}, 32'(low_rst), 32'(n + D));
            for (int i = 0; i < 4; i++) check($sformatf("%s_in%0d_pulses", name, i), 32'(pulses[i]), 32'(exp_in[i]));
            check({name, "_winner"}, 32'(winner), 32'(ew));
            check({name, "_wvalid"}, 32'(winner_valid), 32'(exp_c[ew] > 0));
            check({name, "_sat_winner"}, 32'(s_winner), 32'(sw));
            check({name, "_sat_wvalid"}, 32'(s_winner_valid), 32'(sat_c[sw] > 0));
        end
        if (rst_at == 0) begin
            for (int j = 0; j < 2; j++) begin
                exp_q.push_back(32'(exp_c[j]));
                exp_q.push_back(32'(sat_c[j]));
            end
            for (int j = 0; j < 2; j++) begin
                check($sformatf("%s_count%0d", name, j), 32'(spike_count[j*16 +: 16]), exp_q.pop_front());
                check($sformatf("%s_sat_count%0d", name, j), 32'(s_spike_count[j*3 +: 3]), exp_q.pop_front());
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; rates = '0; num_steps = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("start_during_rst_busy", 32'(busy), 0);
        @(negedge clk);
        check("abort_wins_over_start", 32'(busy), 0);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);

        run_sample("nominal",   {8'd0, 8'd0, 8'd64, 8'd128}, 16, 0, 0, 0);
        run_sample("tie",       {8'd0, 8'd0, 8'd64, 8'd64},  16, 0, 0, 0);
        run_sample("all_zero",  32'd0,                       16, 0, 0, 0);
        run_sample("zero_steps",{8'd9, 8'd9, 8'd64, 8'd128},  0, 0, 0, 0);
        run_sample("abort_run", {8'd0, 8'd0, 8'd64, 8'd128}, 16, S + 1 + 5, 0, 0);
        run_sample("post_abort",{8'd0, 8'd0, 8'd255, 8'd0},  16, 0, 0, 0);
        run_sample("sat_midst", {8'd0, 8'd0, 8'd0, 8'd255},  16, 0, 10, 0);
        run_sample("rst_drain", {8'd0, 8'd0, 8'd64, 8'd128}, 16, 0, 0, S + 16 + 1);
        run_sample("after_rst", {8'd3, 8'd200, 8'd96, 8'd160}, 20, 0, 0, 0);

        for (int t = 0; t < 10; t++) begin
            logic [31:0] rv;
            rv = $urandom;
            if (t % 3 == 0) rv[15:8] = rv[7:0];
            run_sample($sformatf("rand%0d", t), rv, int'($urandom_range(0, 40)), 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #400000;
        n_mis++;
        $display("FAIL watchdog: observed no completion expected finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $fatal(1, "watchdog expired");
    end

endmodule
